score_display_ctrl: RTL and testbench

Score-keeping and display sequencer for the spaceship game's 4-digit seven-segment readout. Accepts add/subtract/clear events from game logic and keeps a saturating 9-bit score. Converts the score to decimal with a sequential shift-add-3 engine instead of combinational divide/modulo. Drives the four hex digit outputs from registered digit latches, so the display only changes on a completed conversion.

---
 rtl/score_display_ctrl_pkg.sv | 29 ++
 rtl/score_display_ctrl_if.sv | 36 +++
 rtl/score_display_ctrl_enc.sv | 25 ++
 rtl/score_display_ctrl.sv | 160 ++++++++++++++++
 tb/tb_score_display_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_display_ctrl_pkg.sv
// ============================================================
// Package : spaceship_pkg
// Shared seven-segment patterns, widths and conversion states.
// Rev     : 1.0
// ============================================================
`default_nettype none

package spaceship_pkg;

  localparam int SCORE_W = 9;
  localparam int BCD_W   = 12;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

endpackage

`default_nettype wire

// File: rtl/score_display_ctrl_if.sv
// ============================================================
// Interface : score_display_ctrl_if
// Game-event inputs and score/display outputs of the score block.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface score_display_ctrl_if;
  import spaceship_pkg::*;

  logic               add_req;
  logic [3:0]         add_amt;
  logic               sub_req;
  logic [3:0]         sub_amt;
  logic               clr;
  logic [SCORE_W-1:0] score;
  logic               sat;
  logic               busy;
  logic [6:0]         hex0;
  logic [6:0]         hex1;
  logic [6:0]         hex2;
  logic [6:0]         hex3;

  modport master (
    output add_req, add_amt, sub_req, sub_amt, clr,
    input  score, sat, busy, hex0, hex1, hex2, hex3
  );

  modport slave (
    input  add_req, add_amt, sub_req, sub_amt, clr,
    output score, sat, busy, hex0, hex1, hex2, hex3
  );

endinterface

`default_nettype wire

// File: rtl/score_display_ctrl_enc.sv
// ============================================================
// Module : bcd_digit_enc
// BCD nibble to active-low seven-segment pattern, with blanking.
// Rev    : 1.0
// ============================================================
`default_nettype none

module bcd_digit_enc
  import spaceship_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble <= 4'd9)) begin
      seg = SEG_DIGIT[nibble];
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_display_ctrl.sv
// ============================================================
// Module : score_display_ctrl
// Saturating 9-bit score with shift-add-3 decimal display sequencer.
// Rev    : 1.0
// ============================================================
`default_nettype none

module score_display_ctrl
  import spaceship_pkg::*;
#(
  parameter int MAX_SCORE = 511,
  parameter bit BLANK_LZ  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_display_ctrl_if.slave  bus
);

  localparam logic [10:0] c_max_net = 11'(MAX_SCORE);
  localparam logic [6:0]  c_hex_hi  = BLANK_LZ ? SEG_BLANK : SEG_DIGIT[0];

  conv_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               sat_q, sat_d;
  logic               dirty_q, dirty_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [6:0]         hex0_q, hex0_d;
  logic [6:0]         hex1_q, hex1_d;
  logic [6:0]         hex2_q, hex2_d;

  logic [10:0]        w_net;
  logic [BCD_W-1:0]   w_adj;
  logic               w_start;
  logic [2:0]         w_blank;
  logic [6:0]         w_seg [3];

  // Bit 10 of the 11-bit net acts as the sign; anything negative clips to 0
  always_comb begin
    w_net   = 11'(score_q)
            + (bus.add_req ? 11'(bus.add_amt) : 11'd0)
            - (bus.sub_req ? 11'(bus.sub_amt) : 11'd0);
    score_d = score_q;
    sat_d   = 1'b0;
    if (bus.clr) begin
      score_d = '0;
    end else if (w_net[10]) begin
      score_d = '0;
      sat_d   = 1'b1;
    end else if (w_net > c_max_net) begin
      score_d = c_max_net[SCORE_W-1:0];
      sat_d   = 1'b1;
    end else begin
      score_d = w_net[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A pending change seen at LOAD chains straight into the next conversion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (dirty_q) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 4'd8) state_d = ST_LOAD;
      ST_LOAD:  state_d = dirty_q ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign w_start = dirty_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));

  always_comb begin
    w_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_blank[0] = 1'b0;
  assign w_blank[1] = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
  assign w_blank[2] = BLANK_LZ && (bcd_q[11:8] == 4'd0);

  generate
    for (genvar g = 0; g < 3; g++) begin : g_enc
      bcd_digit_enc u_enc (
        .nibble (bcd_q[4*g +: 4]),
        .blank  (w_blank[g]),
        .seg    (w_seg[g])
      );
    end
  endgenerate

  always_comb begin
    dirty_d = (w_start ? 1'b0 : dirty_q) | (score_d != score_q);
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    if (w_start) begin
      bin_d = score_q;
      bcd_d = '0;
      cnt_d = '0;
    end else if (state_q == ST_SHIFT) begin
      {bcd_d, bin_d} = {w_adj, bin_q} << 1;
      cnt_d          = cnt_q + 4'd1;
    end
    if (state_q == ST_LOAD) begin
      hex0_d = w_seg[0];
      hex1_d = w_seg[1];
      hex2_d = w_seg[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      sat_q   <= 1'b0;
      dirty_q <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex0_q  <= SEG_DIGIT[0];
      hex1_q  <= c_hex_hi;
      hex2_q  <= c_hex_hi;
    end else begin
      score_q <= score_d;
      sat_q   <= sat_d;
      dirty_q <= dirty_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign bus.score = score_q;
  assign bus.sat   = sat_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.hex0  = hex0_q;
  assign bus.hex1  = hex1_q;
  assign bus.hex2  = hex2_q;
  assign bus.hex3  = c_hex_hi;

endmodule

`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
// ============================================================
// Module : tb_score_display_ctrl
// Directed and random checks of both display variants against a reference model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_score_display_ctrl;

  localparam int MAXV = 511;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_display_ctrl_if bus_a ();
  score_display_ctrl_if bus_b ();

  score_display_ctrl #(.MAX_SCORE(MAXV), .BLANK_LZ(1'b0)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  score_display_ctrl #(.MAX_SCORE(MAXV), .BLANK_LZ(1'b1)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: score value, pending change, and one in-flight conversion job
  int m_score, m_sat, m_disp, m_pend, m_job_active, m_job_left, m_job_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(input int v, input bit blank, input int idx);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (idx)
      0: return seg_of(o);
      1: return (blank && h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
      2: return (blank && h == 0) ? 7'b1111111 : seg_of(h);
      default: return blank ? 7'b1111111 : seg_of(0);
    endcase
  endfunction

  task automatic model_reset();
    m_score = 0; m_sat = 0; m_disp = 0; m_pend = 0;
    m_job_active = 0; m_job_left = 0; m_job_val = 0;
  endtask

  task automatic model_edge(input bit ar, input int aa, input bit sr, input int sa, input bit c);
    int old, net, nxt;
    bit started;
    old     = m_score;
    started = 1'b0;
    if (m_job_active) begin
      m_job_left--;
      if (m_job_left == 0) begin
        m_disp       = m_job_val;
        m_job_active = 0;
      end
    end
    if (!m_job_active && m_pend) begin
      m_job_active = 1;
      m_job_left   = 10;
      m_job_val    = old;
      started      = 1'b1;
    end
    m_sat = 0;
    if (c) begin
      nxt = 0;
    end else begin
      net = old + (ar ? aa : 0) - (sr ? sa : 0);
      if (net < 0)         begin nxt = 0;    m_sat = 1; end
      else if (net > MAXV) begin nxt = MAXV; m_sat = 1; end
      else                       nxt = net;
    end
    m_score = nxt;
    m_pend  = started ? int'(nxt != old) : int'(m_pend != 0 || nxt != old);
  endtask

  task automatic check_all();
    check_val("a.score", 32'(bus_a.score), 32'(m_score));
    check_val("a.sat",   32'(bus_a.sat),   32'(m_sat));
    check_val("a.busy",  32'(bus_a.busy),  32'(m_job_active));
    check_val("a.hex0",  32'(bus_a.hex0),  32'(exp_hex(m_disp, 1'b0, 0)));
    check_val("a.hex1",  32'(bus_a.hex1),  32'(exp_hex(m_disp, 1'b0, 1)));
    check_val("a.hex2",  32'(bus_a.hex2),  32'(exp_hex(m_disp, 1'b0, 2)));
    check_val("a.hex3",  32'(bus_a.hex3),  32'(exp_hex(m_disp, 1'b0, 3)));
    check_val("b.score", 32'(bus_b.score), 32'(m_score));
    check_val("b.sat",   32'(bus_b.sat),   32'(m_sat));
    check_val("b.busy",  32'(bus_b.busy),  32'(m_job_active));
    check_val("b.hex0",  32'(bus_b.hex0),  32'(exp_hex(m_disp, 1'b1, 0)));
    check_val("b.hex1",  32'(bus_b.hex1),  32'(exp_hex(m_disp, 1'b1, 1)));
    check_val("b.hex2",  32'(bus_b.hex2),  32'(exp_hex(m_disp, 1'b1, 2)));
    check_val("b.hex3",  32'(bus_b.hex3),  32'(exp_hex(m_disp, 1'b1, 3)));
  endtask

  task automatic drive(input bit ar, input int aa, input bit sr, input int sa, input bit c);
    bus_a.add_req = ar; bus_a.add_amt = 4'(aa); bus_a.sub_req = sr;
    bus_a.sub_amt = 4'(sa); bus_a.clr = c;
    bus_b.add_req = ar; bus_b.add_amt = 4'(aa); bus_b.sub_req = sr;
    bus_b.sub_amt = 4'(sa); bus_b.clr = c;
  endtask

  // Entered and left on a falling edge
  task automatic cycle(input bit ar, input int aa, input bit sr, input int sa, input bit c);
    drive(ar, aa, sr, sa, c);
    @(posedge clk);
    model_edge(ar, aa, sr, sa, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 0, 1'b0, 0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(20);

    cycle(1'b1, 5, 1'b0, 0, 1'b0);
    idle(14);

    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    repeat (33) cycle(1'b1, 15, 1'b0, 0, 1'b0);
    cycle(1'b1, 10, 1'b0, 0, 1'b0);
    idle(22);
    cycle(1'b1, 15, 1'b0, 0, 1'b0);
    idle(12);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    cycle(1'b1, 8, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 15, 1'b0);
    cycle(1'b0, 0, 1'b1, 15, 1'b0);
    idle(22);

    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    repeat (10) cycle(1'b1, 10, 1'b0, 0, 1'b0);
    idle(22);
    cycle(1'b1, 7, 1'b1, 3, 1'b0);
    idle(12);
    cycle(1'b1, 9, 1'b0, 0, 1'b1);
    idle(12);

    repeat (8) cycle(1'b1, 15, 1'b0, 0, 1'b0);
    idle(22);
    cycle(1'b1, 3, 1'b0, 0, 1'b0);
    idle(3);
    cycle(1'b1, 1, 1'b0, 0, 1'b0);
    idle(2);
    cycle(1'b1, 1, 1'b0, 0, 1'b0);
    idle(25);

    // Asynchronous reset in the middle of a shift sequence
    cycle(1'b1, 15, 1'b0, 0, 1'b0);
    idle(4);
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(1'b1, 9, 1'b0, 0, 1'b0);
    idle(15);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(3, 14));
      end else begin
        cycle(1'($urandom_range(0, 9) < 6), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) < 4), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 31) == 0));
      end
    end
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
